// File: rtl/exu_regfile.sv
// exu_regfile: 32-entry integer register file with x0 hardwired to zero,
// two combinational operand read ports, one storage-only debug read port and
// a per-register pending-write scoreboard used by dispatch for RAW stalls.
// The FORWARD parameter selects whether a same-cycle write-back is bypassed
// to the operand ports (data and pending-clear) or only seen next cycle.
module exu_regfile #(
    parameter int FORWARD     = 1,
    parameter int RFNUM       = 32,
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rf_wbck_i_ena,
    input  logic [XLEN-1:0]        rf_wbck_i_wdat,
    input  logic [RFIDX_WIDTH-1:0] rf_wbck_i_rdidx,
    input  logic [RFIDX_WIDTH-1:0] rf_rs1_idx,
    input  logic [RFIDX_WIDTH-1:0] rf_rs2_idx,
    output logic [XLEN-1:0]        rf_rs1_dat,
    output logic [XLEN-1:0]        rf_rs2_dat,
    output logic                   rf_rs1_busy,
    output logic                   rf_rs2_busy,
    input  logic                   disp_ena,
    input  logic                   disp_rdwen,
    input  logic [RFIDX_WIDTH-1:0] disp_rdidx,
    input  logic                   flush,
    input  logic [RFIDX_WIDTH-1:0] dbg_idx,
    output logic [XLEN-1:0]        dbg_dat
);

    // Architectural storage: entry 0 does not exist, x0 is produced by the read muxes.
    logic [XLEN-1:0]  regs_r [1:RFNUM-1];
    logic [RFNUM-1:1] pend_r;
    logic [RFNUM-1:1] pend_nxt_s;

    logic disp_set_s;
    logic fwd_hit1_s;
    logic fwd_hit2_s;

    // Storage lookup through an explicit compare mux so index 0 never
    // addresses a non-existent entry.
    function automatic logic [XLEN-1:0] stored_dat(input logic [RFIDX_WIDTH-1:0] idx);
        logic [XLEN-1:0] res;
        res = '0;
        for (int i = 1; i < RFNUM; i++) begin
            if (idx == RFIDX_WIDTH'(i)) begin
                res = regs_r[i];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Pending-bit lookup, index 0 always reads as not pending.
    function automatic logic stored_pend(input logic [RFIDX_WIDTH-1:0] idx);
        logic res;
        res = 1'b0;
        for (int i = 1; i < RFNUM; i++) begin
            if (idx == RFIDX_WIDTH'(i)) begin
                res = pend_r[i];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Dispatch qualifiers and same-cycle bypass hits for both operand ports.
    always_comb begin
        disp_set_s = disp_ena & disp_rdwen;
        fwd_hit1_s = (FORWARD != 0) && rf_wbck_i_ena && (rf_wbck_i_rdidx == rf_rs1_idx);
        fwd_hit2_s = (FORWARD != 0) && rf_wbck_i_ena && (rf_wbck_i_rdidx == rf_rs2_idx);
    end

    // Scoreboard next state: flush clears all, a new producer beats a same-cycle write-back clear.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 1; i < RFNUM; i++) begin
            if (flush) begin
                pend_nxt_s[i] = 1'b0;
            end else if (disp_set_s && (disp_rdidx == RFIDX_WIDTH'(i))) begin
                pend_nxt_s[i] = 1'b1;
            end else if (rf_wbck_i_ena && (rf_wbck_i_rdidx == RFIDX_WIDTH'(i))) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
    end

    // State update: reset overrides everything; the write-back is not blocked by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < RFNUM; i++) begin
                regs_r[i] <= '0;
            end
            pend_r <= '0;
        end else begin
            for (int i = 1; i < RFNUM; i++) begin
                if (rf_wbck_i_ena && (rf_wbck_i_rdidx == RFIDX_WIDTH'(i))) begin
                    regs_r[i] <= rf_wbck_i_wdat;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
            pend_r <= pend_nxt_s;
        end
    end

    // Operand port 1: x0, then bypassed write-back, then storage.
    always_comb begin
        if (rf_rs1_idx == '0) begin
            rf_rs1_dat  = '0;
            rf_rs1_busy = 1'b0;
        end else if (fwd_hit1_s) begin
            rf_rs1_dat  = rf_wbck_i_wdat;
            rf_rs1_busy = 1'b0;
        end else begin
            rf_rs1_dat  = stored_dat(rf_rs1_idx);
            rf_rs1_busy = stored_pend(rf_rs1_idx);
        end
    end

    // Operand port 2: same selection as port 1.
    always_comb begin
        if (rf_rs2_idx == '0) begin
            rf_rs2_dat  = '0;
            rf_rs2_busy = 1'b0;
        end else if (fwd_hit2_s) begin
            rf_rs2_dat  = rf_wbck_i_wdat;
            rf_rs2_busy = 1'b0;
        end else begin
            rf_rs2_dat  = stored_dat(rf_rs2_idx);
            rf_rs2_busy = stored_pend(rf_rs2_idx);
        end
    end

    // Debug port reads storage only, never the bypass path.
    always_comb begin
        if (dbg_idx == '0) begin
            dbg_dat = '0;
        end else begin
            dbg_dat = stored_dat(dbg_idx);
        end
    end

endmodule

// File: tb/tb_exu_regfile.sv
// Bench for exu_regfile: one instance with bypass and one without, driven by
// identical inputs; a directed vector table for the corner sequences, then
// random traffic compared against a register/scoreboard reference model.
module tb_exu_regfile;

    logic        clk = 1'b0;
    logic        rst, we, de, dw, fl;
    logic [31:0] wdat;
    logic [4:0]  widx, didx, i1, i2, idbg;
    logic [31:0] d1_a, d2_a, dbg_a, d1_b, d2_b, dbg_b;
    logic        b1_a, b2_a, b1_b, b2_b;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state
    logic [31:0] mregs [32];
    logic        mpend [32];

    always #5 clk = ~clk;

    exu_regfile #(.FORWARD(1)) u_f1 (
        .clk(clk), .rst(rst), .rf_wbck_i_ena(we), .rf_wbck_i_wdat(wdat),
        .rf_wbck_i_rdidx(widx), .rf_rs1_idx(i1), .rf_rs2_idx(i2),
        .rf_rs1_dat(d1_a), .rf_rs2_dat(d2_a), .rf_rs1_busy(b1_a), .rf_rs2_busy(b2_a),
        .disp_ena(de), .disp_rdwen(dw), .disp_rdidx(didx), .flush(fl),
        .dbg_idx(idbg), .dbg_dat(dbg_a));

    exu_regfile #(.FORWARD(0)) u_f0 (
        .clk(clk), .rst(rst), .rf_wbck_i_ena(we), .rf_wbck_i_wdat(wdat),
        .rf_wbck_i_rdidx(widx), .rf_rs1_idx(i1), .rf_rs2_idx(i2),
        .rf_rs1_dat(d1_b), .rf_rs2_dat(d2_b), .rf_rs1_busy(b1_b), .rf_rs2_busy(b2_b),
        .disp_ena(de), .disp_rdwen(dw), .disp_rdidx(didx), .flush(fl),
        .dbg_idx(idbg), .dbg_dat(dbg_b));

    typedef struct {
        logic        rst, we;
        logic [4:0]  widx;
        logic [31:0] wdat;
        logic        de, dw;
        logic [4:0]  didx;
        logic        fl;
        logic [4:0]  i1, i2, idbg;
        logic [31:0] d1a; logic b1a;
        logic [31:0] d1b; logic b1b;
        logic [31:0] d2a; logic b2a;
        logic [31:0] dbg;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [4:0] wi, input logic [31:0] wd,
                       input logic e, input logic ew, input logic [4:0] di, input logic f,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                       input logic [31:0] x1a, input logic y1a, input logic [31:0] x1b,
                       input logic y1b, input logic [31:0] x2a, input logic y2a,
                       input logic [31:0] xd);
        vec_t v;
        v.rst = r; v.we = w; v.widx = wi; v.wdat = wd; v.de = e; v.dw = ew; v.didx = di;
        v.fl = f; v.i1 = a1; v.i2 = a2; v.idbg = ad;
        v.d1a = x1a; v.b1a = y1a; v.d1b = x1b; v.b1b = y1b; v.d2a = x2a; v.b2a = y2a;
        v.dbg = xd;
        vq.push_back(v);
    endtask

    // Spec-level model of the architectural state after one clock edge.
    task automatic model_update();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] = 32'h0;
                mpend[i] = 1'b0;
            end
        end else begin
            if (we && widx != 5'd0) mregs[widx] = wdat;
            if (fl) begin
                for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
            end else begin
                if (we) mpend[widx] = 1'b0;
                if (de && dw && didx != 5'd0) mpend[didx] = 1'b1;
            end
        end
    endtask

    function automatic logic [31:0] exp_dat(input bit fwd, input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (fwd && we && widx == idx) return wdat;
        return mregs[idx];
    endfunction

    function automatic logic exp_busy(input bit fwd, input logic [4:0] idx);
        if (idx == 5'd0) return 1'b0;
        if (fwd && we && widx == idx) return 1'b0;
        return mpend[idx];
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic check_model();
        chk("rnd_rs1_dat_f1", d1_a, exp_dat(1'b1, i1));
        chk("rnd_rs2_dat_f1", d2_a, exp_dat(1'b1, i2));
        chk("rnd_rs1_busy_f1", {31'd0, b1_a}, {31'd0, exp_busy(1'b1, i1)});
        chk("rnd_rs2_busy_f1", {31'd0, b2_a}, {31'd0, exp_busy(1'b1, i2)});
        chk("rnd_rs1_dat_f0", d1_b, exp_dat(1'b0, i1));
        chk("rnd_rs2_dat_f0", d2_b, exp_dat(1'b0, i2));
        chk("rnd_rs1_busy_f0", {31'd0, b1_b}, {31'd0, exp_busy(1'b0, i1)});
        chk("rnd_rs2_busy_f0", {31'd0, b2_b}, {31'd0, exp_busy(1'b0, i2)});
        chk("rnd_dbg_f1", dbg_a, (idbg == 5'd0) ? 32'h0 : mregs[idbg]);
        chk("rnd_dbg_f0", dbg_b, (idbg == 5'd0) ? 32'h0 : mregs[idbg]);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; widx = 5'd0; wdat = 32'h0; de = 1'b0; dw = 1'b0;
        didx = 5'd0; fl = 1'b0; i1 = 5'd0; i2 = 5'd0; idbg = 5'd0;
        for (int i = 0; i < 32; i++) begin
            mregs[i] = 32'hx;
            mpend[i] = 1'bx;
        end
        tick();
        tick();
        rst = 1'b0;

        // Post-reset sweep of every index on all read ports
        for (int i = 0; i < 32; i++) begin
            i1 = 5'(i); i2 = 5'(31 - i); idbg = 5'(i);
            #2;
            chk("rst_rs1_f1", d1_a, 32'h0);
            chk("rst_rs2_f1", d2_a, 32'h0);
            chk("rst_rs1_f0", d1_b, 32'h0);
            chk("rst_rs2_f0", d2_b, 32'h0);
            chk("rst_dbg", dbg_a | dbg_b, 32'h0);
            chk("rst_busy", {28'd0, b1_a, b2_a, b1_b, b2_b}, 32'h0);
        end
        @(posedge clk);
        #1;

        //   rst we widx wdat          de dw didx fl i1 i2 dbg  d1a b1a d1b b1b d2a b2a dbg
        add(0, 1, 5,  32'hDEADBEEF, 0, 0, 0,  0, 5, 0, 5,  32'hDEADBEEF, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        add(0, 0, 0,  32'h0,        0, 0, 0,  0, 5, 0, 5,  32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 32'h0, 0, 32'hDEADBEEF);
        add(0, 1, 0,  32'h12345678, 0, 0, 0,  0, 0, 0, 0,  32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        add(0, 0, 0,  32'h0,        1, 1, 0,  0, 0, 0, 0,  32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        add(0, 0, 0,  32'h0,        0, 0, 0,  0, 0, 0, 0,  32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        add(0, 0, 0,  32'h0,        1, 1, 7,  0, 7, 7, 7,  32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        add(0, 1, 7,  32'hA5A5A5A5, 1, 1, 7,  0, 7, 7, 7,  32'hA5A5A5A5, 0, 32'h0, 1, 32'hA5A5A5A5, 0, 32'h0);
        add(0, 0, 0,  32'h0,        0, 0, 0,  0, 7, 7, 7,  32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5, 1, 32'hA5A5A5A5);
        add(0, 1, 7,  32'h1,        0, 0, 0,  0, 7, 3, 7,  32'h1, 0, 32'hA5A5A5A5, 1, 32'h0, 0, 32'hA5A5A5A5);
        add(0, 0, 0,  32'h0,        1, 1, 3,  0, 7, 3, 7,  32'h1, 0, 32'h1, 0, 32'h0, 0, 32'h1);
        add(0, 0, 0,  32'h0,        1, 1, 9,  0, 3, 9, 9,  32'h0, 1, 32'h0, 1, 32'h0, 0, 32'h0);
        add(0, 0, 0,  32'h0,        1, 1, 12, 0, 9, 12, 9, 32'h0, 1, 32'h0, 1, 32'h0, 0, 32'h0);
        add(0, 1, 9,  32'h55,       0, 0, 0,  1, 9, 12, 9, 32'h55, 0, 32'h0, 1, 32'h0, 1, 32'h0);
        add(0, 0, 0,  32'h0,        0, 0, 0,  0, 9, 3, 9,  32'h55, 0, 32'h55, 0, 32'h0, 0, 32'h55);
        add(0, 0, 0,  32'h0,        0, 0, 0,  0, 12, 3, 12, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        add(0, 0, 0,  32'h0,        1, 1, 4,  0, 4, 4, 4,  32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        add(1, 1, 4,  32'h1,        0, 0, 0,  0, 4, 4, 4,  32'h1, 0, 32'h0, 1, 32'h1, 0, 32'h0);
        add(0, 0, 0,  32'h0,        0, 0, 0,  0, 4, 5, 5,  32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);

        foreach (vq[k]) begin
            rst = vq[k].rst; we = vq[k].we; widx = vq[k].widx; wdat = vq[k].wdat;
            de = vq[k].de; dw = vq[k].dw; didx = vq[k].didx; fl = vq[k].fl;
            i1 = vq[k].i1; i2 = vq[k].i2; idbg = vq[k].idbg;
            @(negedge clk);
            chk($sformatf("vec%0d_rs1_dat_f1", k), d1_a, vq[k].d1a);
            chk($sformatf("vec%0d_rs1_busy_f1", k), {31'd0, b1_a}, {31'd0, vq[k].b1a});
            chk($sformatf("vec%0d_rs1_dat_f0", k), d1_b, vq[k].d1b);
            chk($sformatf("vec%0d_rs1_busy_f0", k), {31'd0, b1_b}, {31'd0, vq[k].b1b});
            chk($sformatf("vec%0d_rs2_dat_f1", k), d2_a, vq[k].d2a);
            chk($sformatf("vec%0d_rs2_busy_f1", k), {31'd0, b2_a}, {31'd0, vq[k].b2a});
            chk($sformatf("vec%0d_dbg_f1", k), dbg_a, vq[k].dbg);
            chk($sformatf("vec%0d_dbg_f0", k), dbg_b, vq[k].dbg);
            tick();
        end

        // Random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            rst  = ($urandom_range(0, 99) == 0);
            fl   = ($urandom_range(0, 15) == 0);
            we   = 1'($urandom_range(0, 1));
            widx = 5'($urandom_range(0, 31));
            wdat = $urandom;
            de   = 1'($urandom_range(0, 1));
            dw   = ($urandom_range(0, 3) != 0);
            didx = 5'($urandom_range(0, 31));
            // Bias reads toward the registers being touched this cycle
            i1   = ($urandom_range(0, 2) == 0) ? widx : 5'($urandom_range(0, 31));
            i2   = ($urandom_range(0, 2) == 0) ? didx : 5'($urandom_range(0, 31));
            idbg = 5'($urandom_range(0, 31));
            @(negedge clk);
            check_model();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
